// File: rtl/pwm_dimmer.sv
// PWM LED dimmer: fixed-length periods whose lit width is sampled from `level`
// only at period boundaries, with a graceful finish-the-period stop.
module pwm_dimmer #(
  parameter int unsigned PERIOD      = 10,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] level,
  output logic        led,
  output logic        period_start,
  output logic [31:0] duty_q,
  output logic        busy
);

  localparam logic [31:0] PERIOD_W = 32'(PERIOD);
  localparam logic [31:0] LAST     = 32'(PERIOD - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t      state;
  logic [31:0] phase;
  logic [31:0] level_clamped_c;
  logic        wrap_c;
  logic        lit_c;

  // Requested duty saturates at a full period (full 32-bit compare).
  assign level_clamped_c = (level > PERIOD_W) ? PERIOD_W : level;
  assign wrap_c          = (phase == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= 32'd0;
      duty_q       <= 32'd0;
      period_start <= 1'b0;
    end else begin
      period_start <= 1'b0;
      case (state)
        IDLE: begin
          phase <= 32'd0;
          if (en) begin
            state        <= RUN;
            duty_q       <= level_clamped_c;
            period_start <= 1'b1;
          end
        end
        RUN, STOP: begin
          phase <= wrap_c ? 32'd0 : phase + 32'd1;
          if (en) begin
            // Resuming from STOP keeps the phase; a new duty only lands at a wrap.
            state <= RUN;
            if (wrap_c) begin
              duty_q       <= level_clamped_c;
              period_start <= 1'b1;
            end
          end else if (state == RUN) begin
            state <= STOP;
          end else if (wrap_c) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          phase <= 32'd0;
        end
      endcase
    end
  end

  // Pure decodes of registered state; no input reaches these outputs.
  assign lit_c = (state != IDLE) && (phase < duty_q);
  assign led   = ACTIVE_HIGH ? lit_c : ~lit_c;
  assign busy  = (state != IDLE);

endmodule

// File: doc/pwm_dimmer.md
PWM_DIMMER -- requirements
Module: pwm_dimmer

Interface
REQ-001 Parameter PERIOD, default 10: PWM period length in clk cycles; legal range 2..2^32-1.
REQ-002 Parameter ACTIVE_HIGH, default 1: LED polarity; 1 = led high when lit, 0 = led low when lit.
REQ-003 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  run request; level-sensitive.
REQ-006 level  input  32  requested brightness, unsigned; the upstream up/down brightness counter drives it directly.
REQ-007 led  output  1  PWM drive to LED pin.
REQ-008 period_start  output  1  one-cycle pulse marking the first cycle of each PWM period.
REQ-009 duty_q  output  32  duty value in force for the current period.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 State machine SHALL have three states: IDLE, RUN, STOP; encoding is free.
REQ-012 Registers SHALL be: state, phase[31:0], duty_q[31:0], period_start; led and busy SHALL be combinational decodes of registers only, with no path from any input.
REQ-013 IDLE: phase held at 0; en=1 at an edge -> next cycle state=RUN, phase=0, duty_q=clamp(level), period_start=1.
REQ-014 clamp(x) SHALL equal min(x, PERIOD), using a full 32-bit unsigned compare.
REQ-015 RUN/STOP: phase SHALL increment by 1 each cycle; when phase==PERIOD-1, phase SHALL wrap to 0 on the next edge.
REQ-016 At a wrap with next state RUN: duty_q=clamp(level) and period_start=1 for that cycle; otherwise period_start=0.
REQ-017 duty_q SHALL change only at period boundaries (REQ-013/REQ-016); a level change mid-period SHALL NOT affect the current period.
REQ-018 RUN with en=0 -> STOP on the next edge; the current period SHALL complete unaltered.
REQ-019 STOP with en=1 -> RUN on the next edge, with no phase discontinuity and no extra period_start.
REQ-020 STOP at phase==PERIOD-1 with en=0 -> IDLE and phase=0 on the next edge, with no period_start pulse.
REQ-021 STOP at phase==PERIOD-1 with en=1: RUN takes priority; behaviour SHALL follow REQ-016.
REQ-022 lit = (state!=IDLE) && (phase < duty_q).
REQ-023 led = lit when ACTIVE_HIGH=1, else ~lit.
REQ-024 duty_q=0 -> led never lit; duty_q=PERIOD -> led lit for every cycle of the period.
REQ-025 Lit cycles per period SHALL equal duty_q exactly, contiguous, starting at phase 0.
REQ-026 busy = (state!=IDLE).

Reset
REQ-027 rst=1 at an edge SHALL give: state=IDLE, phase=0, duty_q=0, period_start=0; hence busy=0 and led inactive (0 when ACTIVE_HIGH=1, 1 when ACTIVE_HIGH=0).
REQ-028 rst SHALL override en and any in-progress period, in any state.
REQ-029 After rst deasserts with en=1, the first period_start SHALL occur on the cycle after the first edge at which rst=0.

Verification (PERIOD=10 unless stated)
REQ-030 rst, then en=1, level=3 -> period_start every 10 cycles; led high for 3 cycles, low for 7, repeating; duty_q=3.
REQ-031 level=0 -> led constantly 0; level=15 -> duty_q=10 and led constantly 1 while RUN; level=32'hFFFF_FFFF -> duty_q=10.
REQ-032 level 3 -> 7 at phase 5 -> current period keeps 3 lit cycles; next period has 7 lit cycles, with duty_q=7 on the period_start cycle.
REQ-033 en drops at phase 4 -> phases 5..9 still run with correct led; IDLE follows; busy=0 at phase 0 with no period_start; en re-asserted at phase 6 -> seamless RUN, normal period_start at wrap.
REQ-034 rst pulsed mid-RUN at phase 2 with level=5 -> next cycle IDLE, phase=0, duty_q=0, led inactive; with en=1, restart per REQ-029.
REQ-035 ACTIVE_HIGH=0, PERIOD=4, level=1 -> led pattern 0,1,1,1 repeating; led=1 in IDLE and reset.
